// File: rtl/dac_sample_player_if.sv
// Write-port bundle for dac_sample_player.
//   wr_clr   : one-cycle pulse, rewinds the write pointer (IDLE only)
//   wr_valid : sample offered by the producer
//   wr_ready : buffer can take a sample this cycle
//   wr_data  : signed sample to store
// master = producer (software/DSP side), slave = sample player.
interface dac_sample_player_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  wr_clr;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_clr, output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_clr, input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/dac_sample_player.sv
// Sample-playback stage feeding the DA9767 driver (signed input style).
// A buffer is filled through wr_if. A start pulse then replays
// min(play_len, wr_cnt) samples, one every rate_div+1 cycles, either once
// or looped. Idle output is 0, which is DAC midscale.
//
// Ports:
//   i_clk_in      system/DAC clock
//   i_rst_n       asynchronous active-low reset
//   wr_if         write port (slave side): wr_clr, wr_valid, wr_ready, wr_data
//   i_start       one-cycle pulse, begin playback (IDLE only)
//   i_stop        one-cycle pulse, abort playback
//   i_loop_en     replay continuously; sampled at each end of pass
//   i_play_len    requested samples per pass
//   i_rate_div    one sample every i_rate_div+1 cycles
//   o_busy        high while not IDLE
//   o_done        one-cycle pulse when a non-looped pass completes
//   o_sample_stb  one-cycle pulse when o_DA_data takes a new sample
//   o_DA_data     signed sample to the DAC driver
module dac_sample_player #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 10,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         i_clk_in,
    input  logic                         i_rst_n,
    dac_sample_player_if.slave           wr_if,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_loop_en,
    input  logic [ADDR_WIDTH:0]          i_play_len,
    input  logic [DIV_WIDTH-1:0]         i_rate_div,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_sample_stb,
    output logic signed [DATA_WIDTH-1:0] o_DA_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Counters are one bit wider than the address so a full buffer
    // (DEPTH samples) and a pass length of DEPTH are representable.
    logic [ADDR_WIDTH:0]          r_wr_cnt;
    logic [ADDR_WIDTH:0]          r_len;
    logic [ADDR_WIDTH:0]          r_rd_addr;   // next address to read
    logic [DIV_WIDTH-1:0]         r_rate_div;
    logic [DIV_WIDTH-1:0]         r_div_cnt;
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_idle;
    logic [ADDR_WIDTH:0]   w_len;
    logic                  w_start_ok;
    logic                  w_abort;
    logic                  w_tick;
    logic                  w_pass_end;
    logic                  w_finish;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_wr_ready;
    logic                  w_wr_fire;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = w_abort ? S_IDLE : S_PLAY;
            S_PLAY:  if (w_abort || w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / control logic ----------------
    // The RAM read register doubles as the output register, so a read
    // issued in cycle N is on o_DA_data in cycle N+1. Reads are therefore
    // paced exactly one period apart: FETCH issues the first, then one
    // every time div_cnt reaches the latched rate_div.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_len      = (i_play_len < r_wr_cnt) ? i_play_len : r_wr_cnt;
        w_start_ok = w_idle && i_start && (w_len != '0);
        w_abort    = !w_idle && i_stop;
        w_tick     = (r_state == S_PLAY) && (r_div_cnt == r_rate_div);
        // A tick with every sample already read is the end of the pass;
        // it lands one full period after the last sample was presented.
        w_pass_end = w_tick && (r_rd_addr == r_len);
        w_finish   = w_pass_end && !i_loop_en && !w_abort;
        w_rd_en    = !w_abort &&
                     ((r_state == S_FETCH) || (w_tick && !(w_pass_end && !i_loop_en)));
        w_rd_idx   = w_pass_end ? '0 : r_rd_addr[ADDR_WIDTH-1:0];
        // Single-port buffer: writes only happen in IDLE, reads never do.
        w_ram_addr = w_idle ? r_wr_cnt[ADDR_WIDTH-1:0] : w_rd_idx;
        w_wr_ready = w_idle && !r_wr_cnt[ADDR_WIDTH];
        // wr_clr wins over a same-cycle write
        w_wr_fire  = wr_if.wr_valid && w_wr_ready && !wr_if.wr_clr;
    end

    assign wr_if.wr_ready = w_wr_ready;
    assign o_busy         = !w_idle;

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt     <= '0;
            r_len        <= '0;
            r_rate_div   <= '0;
            r_rd_addr    <= '0;
            r_div_cnt    <= '0;
            o_DA_data    <= '0;
            o_sample_stb <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            if (w_idle && wr_if.wr_clr) r_wr_cnt <= '0;
            else if (w_wr_fire)         r_wr_cnt <= r_wr_cnt + 1'b1;

            if (w_start_ok) begin
                r_len      <= w_len;
                r_rate_div <= i_rate_div;
                r_rd_addr  <= '0;
            end else if (w_rd_en) begin
                r_rd_addr  <= {1'b0, w_rd_idx} + 1'b1;
            end

            if ((r_state == S_FETCH) || w_tick) r_div_cnt <= '0;
            else if (r_state == S_PLAY)         r_div_cnt <= r_div_cnt + 1'b1;

            o_sample_stb <= w_rd_en;
            o_done       <= w_finish;

            // Return to midscale whenever playback leaves PLAY/FETCH.
            if (w_abort || w_finish) o_DA_data <= '0;
            else if (w_rd_en)        o_DA_data <= r_mem[w_ram_addr];
        end
    end

    // Buffer storage: contents are not reset.
    always_ff @(posedge i_clk_in) begin
        if (w_wr_fire) r_mem[w_ram_addr] <= wr_if.wr_data;
    end

endmodule

// File: tb/tb_dac_sample_player.sv
module tb_dac_sample_player;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               loop_en = 1'b0;
    logic [10:0]        play_len = '0;
    logic [15:0]        rate_div = '0;
    logic               busy, done, stb;
    logic signed [13:0] da;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_sample_player_if #(.DATA_WIDTH(14)) wif();

    dac_sample_player #(.DATA_WIDTH(14), .ADDR_WIDTH(10), .DIV_WIDTH(16)) dut (
        .i_clk_in     (clk),
        .i_rst_n      (rst_n),
        .wr_if        (wif),
        .i_start      (start),
        .i_stop       (stop),
        .i_loop_en    (loop_en),
        .i_play_len   (play_len),
        .i_rate_div   (rate_div),
        .o_busy       (busy),
        .o_done       (done),
        .o_sample_stb (stb),
        .o_DA_data    (da)
    );

    // One row = inputs driven in a cycle + outputs expected in that cycle.
    typedef struct {
        bit start, stop, loop_en;
        int len, rd;
        bit busy, done, stb;
        int da;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit st, bit sp, bit lp, int len, int rd,
                       bit b, bit d, bit s, int dv);
        vec_t v;
        v.start = st; v.stop = sp; v.loop_en = lp; v.len = len; v.rd = rd;
        v.busy = b; v.done = d; v.stb = s; v.da = dv;
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(int val);
        wif.wr_valid = 1'b1;
        wif.wr_data  = 14'(val);
        step();
        wif.wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, nstb, bad, first;
        bit got;
        vec_t v;

        wif.wr_clr = 1'b0; wif.wr_valid = 1'b0; wif.wr_data = '0;

        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stb", stb, 0);
        chk("rst_da", int'(da), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        write_sample(5);
        write_sample(-3);
        write_sample(8191);
        write_sample(-8192);
        chk("wr_ready_after_4", wif.wr_ready, 1);

        // A: one pass, rate_div=0; len/rate changes mid-pass must be ignored
        add(1,0,0,4,0, 0,0,0,0);
        add(0,0,0,4,0, 1,0,0,0);
        add(0,0,0,4,0, 1,0,1,5);
        add(0,0,0,1,7, 1,0,1,-3);
        add(0,0,0,1,7, 1,0,1,8191);
        add(0,0,0,4,0, 1,0,1,-8192);
        add(0,0,0,4,0, 0,1,0,0);
        add(0,0,0,4,0, 0,0,0,0);
        // B: rate_div=2, strobes at T+2,5,8,11, done at T+14
        add(1,0,0,4,2, 0,0,0,0);
        add(0,0,0,4,2, 1,0,0,0);
        add(0,0,0,4,2, 1,0,1,5);
        add(0,0,0,4,2, 1,0,0,5);
        add(0,0,0,4,2, 1,0,0,5);
        add(0,0,0,4,2, 1,0,1,-3);
        add(0,0,0,4,2, 1,0,0,-3);
        add(0,0,0,4,2, 1,0,0,-3);
        add(0,0,0,4,2, 1,0,1,8191);
        add(0,0,0,4,2, 1,0,0,8191);
        add(0,0,0,4,2, 1,0,0,8191);
        add(0,0,0,4,2, 1,0,1,-8192);
        add(0,0,0,4,2, 1,0,0,-8192);
        add(0,0,0,4,2, 1,0,0,-8192);
        add(0,0,0,4,2, 0,1,0,0);
        add(0,0,0,4,2, 0,0,0,0);
        // C: play_len=10 clipped to wr_cnt=4
        add(1,0,0,10,0, 0,0,0,0);
        add(0,0,0,10,0, 1,0,0,0);
        add(0,0,0,10,0, 1,0,1,5);
        add(0,0,0,10,0, 1,0,1,-3);
        add(0,0,0,10,0, 1,0,1,8191);
        add(0,0,0,10,0, 1,0,1,-8192);
        add(0,0,0,10,0, 0,1,0,0);
        add(0,0,0,10,0, 0,0,0,0);
        // D: loop len=2 rate_div=1, loop dropped after the first wrap
        add(1,0,1,2,1, 0,0,0,0);
        add(0,0,1,2,1, 1,0,0,0);
        add(0,0,1,2,1, 1,0,1,5);
        add(0,0,1,2,1, 1,0,0,5);
        add(0,0,1,2,1, 1,0,1,-3);
        add(0,0,1,2,1, 1,0,0,-3);
        add(0,0,0,2,1, 1,0,1,5);
        add(0,0,0,2,1, 1,0,0,5);
        add(0,0,0,2,1, 1,0,1,-3);
        add(0,0,0,2,1, 1,0,0,-3);
        add(0,0,0,2,1, 0,1,0,0);
        add(0,0,0,2,1, 0,0,0,0);
        // E: stop at T+3 -> IDLE at T+4, no done
        add(1,0,0,4,0, 0,0,0,0);
        add(0,0,0,4,0, 1,0,0,0);
        add(0,0,0,4,0, 1,0,1,5);
        add(0,1,0,4,0, 1,0,1,-3);
        add(0,0,0,4,0, 0,0,0,0);
        add(0,0,0,4,0, 0,0,0,0);
        // F: play_len=0 -> start ignored
        add(1,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            start = v.start; stop = v.stop; loop_en = v.loop_en;
            play_len = 11'(v.len); rate_div = 16'(v.rd);
            @(negedge clk);
            chk($sformatf("row%0d_busy", i), busy, v.busy);
            chk($sformatf("row%0d_done", i), done, v.done);
            chk($sformatf("row%0d_stb", i), stb, v.stb);
            chk($sformatf("row%0d_da", i), int'(da), v.da);
            step();
        end
        start = 0; stop = 0; loop_en = 0;

        // reset in the middle of PLAY
        play_len = 11'd4; rate_div = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_da", int'(da), 5);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_da", int'(da), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_stb", stb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start = 1'b1;
        @(negedge clk);
        chk("empty_start_busy0", busy, 0);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("empty_start_busy1", busy, 0);
        chk("empty_wr_ready", wif.wr_ready, 1);
        step();

        // fill the whole buffer with wr_valid held high
        acc = 0;
        wif.wr_valid = 1'b1;
        for (int c = 0; c < 1030; c++) begin
            wif.wr_data = 14'(100 + acc);
            @(negedge clk);
            if (wif.wr_ready) acc++;
            step();
        end
        chk("wr_accepts", acc, 1024);
        chk("wr_ready_full", wif.wr_ready, 0);
        wif.wr_valid = 1'b0;

        play_len = 11'd1024; rate_div = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        nstb = 0; bad = 0; first = -1; got = 0;
        for (int c = 0; c < 1100 && !got; c++) begin
            @(negedge clk);
            if (stb) begin
                if (nstb == 0) first = int'(da);
                if (int'(da) != 100 + nstb) bad++;
                nstb++;
            end
            if (done) got = 1;
            step();
        end
        chk("full_first_sample", first, 100);
        chk("full_data_errors", bad, 0);
        chk("full_stb_count", nstb, 1024);
        chk("full_done_seen", got, 1);

        // wr_clr rewinds the write count
        wif.wr_clr = 1'b1;
        step();
        wif.wr_clr = 1'b0;
        @(negedge clk);
        chk("clr_wr_ready", wif.wr_ready, 1);
        step();
        play_len = 11'd4; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("clr_start_ignored", busy, 0);
        step();

        // wr_clr with a same-cycle write: the write is dropped
        wif.wr_clr = 1'b1; wif.wr_valid = 1'b1; wif.wr_data = 14'd7;
        step();
        wif.wr_clr = 1'b0; wif.wr_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("clr_drops_write", busy, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dac_sample_player.md
Name: dac_sample_player

Overview:
- Sample-playback stage that sits directly upstream of the DA9767 DAC driver.
- Software or an upstream DSP fills an on-chip buffer through a valid/ready write port. A start command then replays the stored waveform at a programmable rate, once or looped.
- The DA_data output is a 14-bit signed sample feeding the driver with INPUT_STYLE="signed". Idle output is 0, which the driver maps to DAC midscale.

Parameters:
- DATA_WIDTH, 14, sample width; must match the driver INPUT_WIDTH.
- ADDR_WIDTH, 10, buffer depth is 2**ADDR_WIDTH samples (default 1024).
- DIV_WIDTH, 16, width of the sample-rate divider.

Ports:
- clk_in  in  1  system/DAC clock; the same net drives DA9767 clk_in.
- rst_n  in  1  asynchronous active-low reset.
- wr_clr  in  1  one-cycle pulse; clears the write count (honoured only in IDLE).
- wr_valid  in  1  write sample valid.
- wr_ready  out  1  buffer accepts a sample.
- wr_data  in  DATA_WIDTH  signed sample to store.
- start  in  1  one-cycle pulse; begin playback.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  replay continuously; sampled at each end-of-pass.
- play_len  in  ADDR_WIDTH+1  requested number of samples per pass.
- rate_div  in  DIV_WIDTH  output one sample every rate_div+1 cycles.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a non-looped pass completes.
- sample_stb  out  1  one-cycle pulse when DA_data takes a new sample.
- DA_data  out  DATA_WIDTH  signed sample to DA9767.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - wr_cnt = 0.
  - DA_data = 0, busy = 0, done = 0, sample_stb = 0.
  - Buffer contents are undefined.
- Buffer: single-port synchronous RAM, 2**ADDR_WIDTH x DATA_WIDTH, read latency 1 cycle.
- Write port:
  - wr_ready = (state==IDLE) && (wr_cnt < 2**ADDR_WIDTH).
  - When wr_valid && wr_ready: write wr_data to mem[wr_cnt], then wr_cnt++.
  - wr_clr in IDLE sets wr_cnt = 0 and takes priority over a same-cycle write, which is dropped.
  - wr_clr outside IDLE is ignored.
  - wr_valid while wr_ready=0 has no effect; the upstream holds its data.
- Start:
  - In IDLE, start computes len = min(play_len, wr_cnt).
  - If len==0, start is ignored: no busy, no done.
  - Otherwise latch len and rate_div, set rd_addr = 0, go to FETCH.
  - start outside IDLE is ignored.
  - start and wr_valid in the same cycle: the write is accepted first and counts toward wr_cnt only for the next start.
- States:
  - IDLE -> FETCH on an accepted start.
  - FETCH (1 cycle): issue RAM read of rd_addr, then go to PLAY.
  - PLAY: the first cycle in PLAY loads DA_data = RAM output, pulses sample_stb and clears div_cnt.
  - PLAY pacing: div_cnt counts 0..rate_div_latched. At div_cnt==rate_div_latched, the next address is read so that the next sample lands exactly rate_div+1 cycles after the previous sample_stb.
  - End of pass: the last sample (rd_addr==len-1) is held for its full rate_div+1 period.
  - If loop_en is 1 at that point: rd_addr wraps to 0 with no gap, and the period stays rate_div+1 across the wrap.
  - If loop_en is 0: go to IDLE, pulse done for 1 cycle, and set DA_data = 0 in that same cycle.
- Latency: start accepted at cycle T -> first sample_stb and DA_data valid at T+2.
- Stop:
  - stop in FETCH/PLAY: next cycle go to IDLE, DA_data = 0, no done pulse, wr_cnt preserved.
  - stop in IDLE is ignored.
  - stop takes precedence over a same-cycle end-of-pass, so done is not pulsed.
- Mid-pass changes: play_len and rate_div changes during playback have no effect until the next start.
- Reset mid-playback: immediate IDLE and DA_data = 0 asynchronously, so the DAC goes to midscale.
- Arithmetic: samples pass through unmodified, with no saturation or scaling. div_cnt and rd_addr wrap only as specified; rate_div = 2**DIV_WIDTH-1 is legal.

Test Plan:
- Write 5, -3, 8191, -8192 (wr_cnt=4), play_len=4, rate_div=0, loop_en=0, start at T:
  - DA_data = 5, -3, 8191, -8192 on T+2..T+5.
  - done at T+6 with DA_data=0 and busy low.
- Same buffer, rate_div=2:
  - sample_stb at T+2, T+5, T+8, T+11.
  - done at T+14.
- loop_en=1, play_len=2, rate_div=1:
  - sequence 5,5,-3,-3,5,5,... continuous across the wrap with no done.
  - Drop loop_en: the current pass finishes, then done.
- Write 1024 samples with wr_valid held high:
  - wr_ready falls after the 1024th accept; the 1025th is not written.
  - wr_clr -> wr_ready=1 and wr_cnt=0.
- Edge commands:
  - play_len=0, or wr_cnt=0 -> start ignored, busy stays 0.
  - play_len=10 with wr_cnt=4 -> exactly 4 samples played.
- stop at T+3 during playback -> IDLE at T+4, DA_data=0, no done.
- rst_n low mid-PLAY -> DA_data=0 and busy=0 immediately.
- After release, start -> ignored (wr_cnt=0).
